matrix_keypad_scan: RTL and testbench
=====================================

Name: matrix_keypad_scan

Overview:
Parametrised row/column keypad scanner, the next generation of our 4x4 keypad front end. It drives one active-low column at a time and samples the active-low rows. It assembles complete scan frames, rejects ghosting multi-key frames and debounces both press and release over whole frames. Each debounced press is queued as a key code in a small FIFO with a valid/ready handshake, feeding the floor-request logic.

Parameters:
ROWS, 4, number of row inputs (key_r width), >=1
COLS, 4, number of column drives (key_c width), >=2
SCAN_DIV, 500, clk cycles each column is driven (dwell), >=2
DEBOUNCE, 4, consecutive identical frames needed to accept a press or a release, >=1
FIFO_DEPTH, 4, key event queue depth, power of 2, >=2
KW (localparam), clog2(ROWS*COLS), key code width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_r  in  ROWS  row sense, active-low, asynchronous to clk
key_c  out  COLS  column drive, active-low, exactly one bit low
key_code  out  KW  code at FIFO head = col*ROWS + row
key_valid  out  1  FIFO not empty
key_ready  in  1  consumer accepts key_code when key_valid && key_ready
held  out  1  a debounced key is currently down (states HELD or RELEASE_WAIT)
overflow  out  1  sticky: a debounced press was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at a clk edge) gives: col_idx=0, key_c=~1 (column 0 driven), dwell counter=0, FSM=IDLE, FIFO empty, key_valid=0, key_code=0, held=0, overflow=0, frame and synchroniser cleared. Reset mid-operation discards the queued events and debounce progress.
- key_r passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Dwell counter runs 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1 (tick):
  - the synchronised rows are latched into frame bits [col_idx*ROWS +: ROWS], inverted so that 1 = pressed;
  - col_idx advances, wrapping COLS-1 -> 0;
  - key_c updates to ~(1<<col_idx) on the next cycle.
- A frame completes on the tick with col_idx=COLS-1. Frame period = COLS*SCAN_DIV cycles.
- Frame classification:
  - NONE: 0 bits set.
  - SINGLE(c): exactly 1 bit set, c = its index.
  - MULTI: 2 or more bits set.
- The FSM advances only on frame completion; cnt is its frame counter:
  - IDLE: SINGLE(c) -> cand=c, cnt=1. If DEBOUNCE=1, push c and go to HELD; otherwise go to PRESS_WAIT. NONE or MULTI -> stay.
  - PRESS_WAIT: SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE, push cand and go to HELD. SINGLE(other) -> cand=other, cnt=1. NONE or MULTI -> IDLE.
  - HELD: cand bit set (any class) -> stay. Cand bit clear -> cnt=1, go to RELEASE_WAIT; if DEBOUNCE=1, go straight to IDLE.
  - RELEASE_WAIT: cand bit set -> HELD. Cand bit clear -> cnt++; when cnt reaches DEBOUNCE -> IDLE.
- One event per press. There is no autorepeat. A second key pressed while HELD is not registered until the first key's release has been accepted.
- FIFO:
  - push takes 1 cycle: key_valid rises on the cycle after the completing frame tick;
  - key_code always equals the head entry;
  - pop occurs when key_valid && key_ready.
- FIFO boundary cases:
  - Push when full with no pop: the event is dropped and overflow is set; it clears only on rst.
  - Push and pop in the same cycle when full: both happen, count is unchanged, no overflow.
  - Push when empty: key_ready has no effect that cycle because key_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- key_code is 0 while the FIFO is empty.

Test Plan:
(bench: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4; frame = 16 cycles)
1. Assert rst for 2 cycles, then release -> key_c=4'b1110, key_valid=0, held=0, overflow=0. key_c becomes 4'b1101 after 4 cycles and is back at 4'b1110 after 16 cycles.
2. Hold key_r[1] low whenever column 2 is driven, for 4 frames, with key_ready=0 -> exactly one event, key_code=9. key_valid rises 1 cycle after the second frame completes and held=1. Then key_ready=1 -> pop, key_valid=0. After release, held drops after 2 NONE frames.
3. Bounce: row 0 / col 0 pressed for 1 frame, released for 1 frame, repeated 3 times -> no event, held stays 0.
4. Ghosting: codes 0 and 5 pressed simultaneously for 4 frames -> no event, held=0. Releasing code 5 then gives code 0 as SINGLE, and it is accepted after 2 frames.
5. Overflow: key_ready=0, five debounced presses with codes 3, 7, 11, 15, 2 -> FIFO holds 3, 7, 11, 15, overflow=1, code 2 lost. Then key_ready=1 in the same cycle as a sixth push (code 4) -> pops 3 in that cycle, then 7, 11, 15, 4 in order; overflow stays 1.
6. Assert rst while in HELD with 2 entries queued -> all outputs return to reset values and the FIFO is empty. The key stays held, so a new event with the same code appears 2 frames after reset release.

Source files
------------

// File: rtl/matrix_keypad_scan.sv
// Row/column keypad scanner: drives one active-low column at a time,
// builds full scan frames, rejects ghosting frames, debounces press and
// release over whole frames and queues one key code per press in a FIFO.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   key_r     in   [ROWS] row sense, active-low, asynchronous
//   key_c     out  [COLS] column drive, active-low, one bit low
//   key_code  out  [KW]   code at FIFO head (col*ROWS + row), 0 when empty
//   key_valid out  FIFO not empty
//   key_ready in   consumer accepts key_code when key_valid && key_ready
//   held      out  a debounced key is currently down
//   overflow  out  sticky: a debounced press was dropped on a full FIFO
module matrix_keypad_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 500,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int KW        = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] key_r,
    output logic [COLS-1:0] key_c,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            held,
    output logic            overflow
);

    localparam int N   = ROWS * COLS;
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int CIW = $clog2(COLS);
    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Scan and frame capture
    logic [ROWS-1:0] r_meta;
    logic [ROWS-1:0] r_sync;
    logic [DW-1:0]   dwell;
    logic [CIW-1:0]  col_idx;
    logic [N-1:0]    frame;
    logic [N-1:0]    frame_full;
    logic            tick;
    logic            frame_done;

    assign tick       = (dwell == DW'(SCAN_DIV - 1));
    assign frame_done = tick && (col_idx == CIW'(COLS - 1));

    // Synchroniser resets to "all released" so no phantom press is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= '1;
            r_sync  <= '1;
            dwell   <= '0;
            col_idx <= '0;
            frame   <= '0;
        end else begin
            r_meta <= key_r;
            r_sync <= r_meta;
            if (tick) begin
                dwell <= '0;
                frame[col_idx*ROWS +: ROWS] <= ~r_sync;
                if (col_idx == CIW'(COLS - 1))
                    col_idx <= '0;
                else
                    col_idx <= col_idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    always_comb begin
        key_c          = '1;
        key_c[col_idx] = 1'b0;
    end

    // Frame as it will look after this tick: last column taken live
    always_comb begin
        frame_full = frame;
        frame_full[(COLS-1)*ROWS +: ROWS] = ~r_sync;
    end

    // Classification: nset saturates at 2 (MULTI)
    logic [1:0]    nset;
    logic [KW-1:0] hit_idx;
    logic          single;

    always_comb begin
        nset    = 2'd0;
        hit_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_full[i]) begin
                if (nset != 2'd2)
                    nset = nset + 2'd1;
                hit_idx = KW'(i);
            end
        end
    end

    assign single = (nset == 2'd1);

    // Debounce FSM
    state_t        state, state_nx;
    logic [KW-1:0] cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] cnt_inc;
    logic          cand_bit;
    logic          push;

    assign cnt_inc  = cnt + 1'b1;
    assign cand_bit = frame_full[cand];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    if (single) begin
                        cand_nx  = hit_idx;
                        cnt_nx   = CW'(1);
                        state_nx = (DEBOUNCE == 1) ? HELD : PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (single && hit_idx == cand) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE))
                            state_nx = HELD;
                    end else if (single) begin
                        cand_nx = hit_idx;
                        cnt_nx  = CW'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
                HELD: begin
                    if (!cand_bit) begin
                        cnt_nx   = CW'(1);
                        state_nx = (DEBOUNCE == 1) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (cand_bit) begin
                        state_nx = HELD;
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE))
                            state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // When a push fires, hit_idx equals the accepted candidate
    always_comb begin
        held = (state == HELD) || (state == RELEASE_WAIT);
        push = 1'b0;
        if (frame_done && single) begin
            if (state == IDLE && DEBOUNCE == 1)
                push = 1'b1;
            if (state == PRESS_WAIT && hit_idx == cand &&
                cnt_inc == CW'(DEBOUNCE))
                push = 1'b1;
        end
    end

    // Key event FIFO
    logic [KW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign key_valid = (count != '0);
    assign pop       = key_valid && key_ready;
    // A pop in the same cycle frees the slot for a push on a full FIFO
    assign do_push   = push && (!full || pop);
    assign key_code  = key_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= hit_idx;
    end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// Directed bench for matrix_keypad_scan with a 4x4 keypad model.
// Ports: none (top-level bench).
module tb_matrix_keypad_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ready;
    logic [3:0]  key_r;
    logic [3:0]  key_c;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        held;
    logic        overflow;
    logic [15:0] pressed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_keypad_scan #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .key_r(key_r), .key_c(key_c),
        .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .held(held), .overflow(overflow)
    );

    // Keypad: a pressed key pulls its row low when its column is driven
    always_comb begin
        key_r = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (key_c[c] === 1'b0 && pressed[c*4+r])
                    key_r[r] = 1'b0;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame boundaries fall every 16 negedges after this returns
    task automatic do_reset;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Press for 2 frames (accepted), release for 2 frames (back to idle)
    task automatic press_key(input int code);
        pressed = 16'(1) << code;
        cyc(32);
        pressed = '0;
        cyc(32);
    endtask

    task automatic test_reset;
        pressed   = '0;
        key_ready = 1'b0;
        do_reset();
        n_checks++;
        if (key_c !== 4'b1110) begin
            n_fail++; $display("FAIL reset_key_c: got %b want 1110", key_c);
        end
        n_checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: valid=%b code=%0d want 0/0",
                     key_valid, key_code);
        end
        n_checks++;
        if (held !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: held=%b ovf=%b want 0/0",
                     held, overflow);
        end
        cyc(3);
        n_checks++;
        if (key_c !== 4'b1110) begin
            n_fail++; $display("FAIL dwell_c0: got %b want 1110", key_c);
        end
        cyc(1);
        n_checks++;
        if (key_c !== 4'b1101) begin
            n_fail++; $display("FAIL dwell_c1: got %b want 1101", key_c);
        end
        cyc(12);
        n_checks++;
        if (key_c !== 4'b1110) begin
            n_fail++; $display("FAIL frame_wrap: got %b want 1110", key_c);
        end
    endtask

    task automatic test_single_press;
        key_ready = 1'b0;
        pressed   = '0;
        do_reset();
        pressed = 16'(1) << 9;
        cyc(16);
        n_checks++;
        if (key_valid !== 1'b0 || held !== 1'b0) begin
            n_fail++;
            $display("FAIL press_f1: valid=%b held=%b want 0/0",
                     key_valid, held);
        end
        cyc(15);
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL press_early: valid=%b want 0", key_valid);
        end
        cyc(1);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL press_f2: valid=%b code=%0d held=%b want 1/9/1",
                     key_valid, key_code, held);
        end
        cyc(32);
        pressed   = '0;
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd0) begin
            n_fail++;
            $display("FAIL one_event: valid=%b code=%0d want 0/0",
                     key_valid, key_code);
        end
        cyc(15);
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++; $display("FAIL release_f1: held=%b want 1", held);
        end
        cyc(16);
        n_checks++;
        if (held !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_f2: held=%b valid=%b want 0/0",
                     held, key_valid);
        end
    endtask

    task automatic test_bounce;
        key_ready = 1'b0;
        pressed   = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pressed = 16'(1);
            cyc(16);
            n_checks++;
            if (held !== 1'b0 || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_on%0d: held=%b valid=%b want 0/0",
                         i, held, key_valid);
            end
            pressed = '0;
            cyc(16);
            n_checks++;
            if (held !== 1'b0 || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_off%0d: held=%b valid=%b want 0/0",
                         i, held, key_valid);
            end
        end
    endtask

    task automatic test_ghosting;
        key_ready = 1'b0;
        pressed   = '0;
        do_reset();
        pressed = 16'h0021;
        cyc(64);
        n_checks++;
        if (held !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ghost: held=%b valid=%b want 0/0", held, key_valid);
        end
        pressed = 16'h0001;
        cyc(16);
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL ghost_f1: valid=%b want 0", key_valid);
        end
        cyc(16);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd0 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL ghost_f2: valid=%b code=%0d held=%b want 1/0/1",
                     key_valid, key_code, held);
        end
        pressed = '0;
    endtask

    task automatic test_overflow;
        int exp_codes[3] = '{11, 15, 4};
        key_ready = 1'b0;
        pressed   = '0;
        do_reset();
        press_key(3);
        press_key(7);
        press_key(11);
        press_key(15);
        n_checks++;
        if (overflow !== 1'b0 || key_valid !== 1'b1 || key_code !== 4'd3) begin
            n_fail++;
            $display("FAIL fill4: ovf=%b valid=%b code=%0d want 0/1/3",
                     overflow, key_valid, key_code);
        end
        press_key(2);
        n_checks++;
        if (overflow !== 1'b1 || key_code !== 4'd3) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b code=%0d want 1/3",
                     overflow, key_code);
        end
        pressed = 16'(1) << 4;
        cyc(31);
        n_checks++;
        if (key_code !== 4'd3) begin
            n_fail++; $display("FAIL pre_pushpop: code=%0d want 3", key_code);
        end
        key_ready = 1'b1;
        cyc(1);
        n_checks++;
        if (key_code !== 4'd7 || key_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop: code=%0d valid=%b ovf=%b want 7/1/1",
                     key_code, key_valid, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_checks++;
            if (key_code !== 4'(exp_codes[i]) || key_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain%0d: code=%0d valid=%b want %0d/1",
                         i, key_code, key_valid, exp_codes[i]);
            end
        end
        cyc(1);
        key_ready = 1'b0;
        n_checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: valid=%b code=%0d ovf=%b want 0/0/1",
                     key_valid, key_code, overflow);
        end
        pressed = '0;
    endtask

    task automatic test_reset_held;
        key_ready = 1'b0;
        pressed   = '0;
        do_reset();
        press_key(3);
        pressed = 16'(1) << 6;
        cyc(32);
        n_checks++;
        if (key_valid !== 1'b1 || held !== 1'b1 || key_code !== 4'd3) begin
            n_fail++;
            $display("FAIL pre_rst: valid=%b held=%b code=%0d want 1/1/3",
                     key_valid, held, key_code);
        end
        do_reset();
        n_checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd0 || held !== 1'b0 ||
            overflow !== 1'b0 || key_c !== 4'b1110) begin
            n_fail++;
            $display("FAIL mid_rst: valid=%b code=%0d held=%b ovf=%b c=%b want 0/0/0/0/1110",
                     key_valid, key_code, held, overflow, key_c);
        end
        cyc(16);
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_f1: valid=%b want 0", key_valid);
        end
        cyc(16);
        n_checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd6 || held !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_f2: valid=%b code=%0d held=%b want 1/6/1",
                     key_valid, key_code, held);
        end
        pressed = '0;
    endtask

    initial begin
        rst       = 1'b1;
        key_ready = 1'b0;
        pressed   = '0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_ghosting();
        test_overflow();
        test_reset_held();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
